seq_1010_frame_tx: RTL

//  Serial frame transmitter for the 1010-marker link. Emits a non-overlapping 1010 preamble,

---
 rtl/seq_1010_frame_tx.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/seq_1010_frame_tx.sv
`default_nettype none
// ============================================================================
// Module   : seq_1010_frame_tx
// Purpose  : Serial frame transmitter for the 1010-marker link. After a word
//            is accepted over a valid/ready handshake it drives a 1010
//            preamble, the word MSB-first, an optional even-parity bit, and
//            GAP idle cycles onto the registered serial line y.
// Ports    : clk        - rising-edge clock
//            rst        - synchronous reset, active-high
//            din        - payload word, sampled only on handshake
//            din_valid  - payload word available
//            din_ready  - block can accept a word (combinational, IDLE state)
//            y          - serial line output, registered, idle level 0
//            busy       - registered, high from first preamble bit through
//                         last gap cycle
//            frame_done - registered, one-cycle pulse on the last frame bit
// Config   : SEQ_1010_TX_PARITY_EN - when defined, a PAR state appends an
//            even-parity bit (^din) after din[0]; frame_done moves onto it.
// Revision : 1.0 - initial release
// ============================================================================
module seq_1010_frame_tx #(
    parameter int DATA_W = 8,
    parameter int GAP    = 2
) (
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire logic [DATA_W-1:0] din,
    input  wire logic              din_valid,
    output logic                   din_ready,
    output logic                   y,
    output logic                   busy,
    output logic                   frame_done
);

    // One counter serves preamble, payload and gap phases, so it is sized
    // for the longest of them; it is cleared on every phase entry.
    localparam int c_CNT_N0 = (DATA_W > 4) ? DATA_W : 4;
    localparam int c_CNT_N  = (GAP > c_CNT_N0) ? GAP : c_CNT_N0;
    localparam int c_CNT_W  = $clog2(c_CNT_N);

    localparam logic [c_CNT_W-1:0] c_CNT_ONE   = c_CNT_W'(1);
    localparam logic [c_CNT_W-1:0] c_PRE_LAST  = c_CNT_W'(3);
    localparam logic [c_CNT_W-1:0] c_DATA_LAST = c_CNT_W'(DATA_W - 1);
    localparam logic [c_CNT_W-1:0] c_GAP_LAST  = c_CNT_W'((GAP > 0) ? GAP - 1 : 0);

    localparam logic [2:0] c_S_IDLE = 3'd0;
    localparam logic [2:0] c_S_PRE  = 3'd1;
    localparam logic [2:0] c_S_DATA = 3'd2;
`ifdef SEQ_1010_TX_PARITY_EN
    localparam logic [2:0] c_S_PAR  = 3'd3;
`endif
    localparam logic [2:0] c_S_GAP  = 3'd4;

    logic [2:0]         r_state;
    logic [2:0]         w_state_nxt;
    logic [c_CNT_W-1:0] r_cnt;
    logic [c_CNT_W-1:0] w_cnt_nxt;
    logic [DATA_W-1:0]  r_sh;
    logic [DATA_W-1:0]  w_sh_nxt;
    logic [DATA_W-1:0]  w_sh_shl;
    logic               r_y;
    logic               w_y_nxt;
    logic               r_busy;
    logic               w_busy_nxt;
    logic               r_done;
    logic               w_done_nxt;
    logic               w_accept;
`ifdef SEQ_1010_TX_PARITY_EN
    logic               r_par;
    logic               w_par_nxt;
`endif

    assign din_ready  = (r_state == c_S_IDLE);
    assign w_accept   = din_valid & din_ready;
    assign w_sh_shl   = r_sh << 1;
    assign y          = r_y;
    assign busy       = r_busy;
    assign frame_done = r_done;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_sh_nxt    = r_sh;
        w_y_nxt     = 1'b0;
        w_busy_nxt  = r_busy;
        w_done_nxt  = 1'b0;
`ifdef SEQ_1010_TX_PARITY_EN
        w_par_nxt   = r_par;
`endif
        case (r_state)
            c_S_IDLE: begin
                w_busy_nxt = 1'b0;
                if (w_accept) begin
                    w_state_nxt = c_S_PRE;
                    w_cnt_nxt   = '0;
                    w_sh_nxt    = din;
`ifdef SEQ_1010_TX_PARITY_EN
                    w_par_nxt   = ^din;
`endif
                    w_y_nxt     = 1'b1;
                    w_busy_nxt  = 1'b1;
                end
            end

            c_S_PRE: begin
                if (r_cnt == c_PRE_LAST) begin
                    w_state_nxt = c_S_DATA;
                    w_cnt_nxt   = '0;
                    w_y_nxt     = r_sh[DATA_W-1];
`ifndef SEQ_1010_TX_PARITY_EN
                    // A one-bit payload is also the last frame bit.
                    w_done_nxt  = (DATA_W == 1);
`endif
                end else begin
                    // Preamble bit i is ~i[0]; the next bit (i+1) is therefore i[0].
                    w_cnt_nxt = r_cnt + c_CNT_ONE;
                    w_y_nxt   = r_cnt[0];
                end
            end

            c_S_DATA: begin
                if (r_cnt == c_DATA_LAST) begin
`ifdef SEQ_1010_TX_PARITY_EN
                    w_state_nxt = c_S_PAR;
                    w_y_nxt     = r_par;
                    w_done_nxt  = 1'b1;
`else
                    if (GAP == 0) begin
                        w_state_nxt = c_S_IDLE;
                        w_busy_nxt  = 1'b0;
                    end else begin
                        w_state_nxt = c_S_GAP;
                        w_cnt_nxt   = '0;
                    end
`endif
                end else begin
                    w_cnt_nxt = r_cnt + c_CNT_ONE;
                    w_sh_nxt  = w_sh_shl;
                    w_y_nxt   = w_sh_shl[DATA_W-1];
`ifndef SEQ_1010_TX_PARITY_EN
                    w_done_nxt = ((r_cnt + c_CNT_ONE) == c_DATA_LAST);
`endif
                end
            end

`ifdef SEQ_1010_TX_PARITY_EN
            c_S_PAR: begin
                if (GAP == 0) begin
                    w_state_nxt = c_S_IDLE;
                    w_busy_nxt  = 1'b0;
                end else begin
                    w_state_nxt = c_S_GAP;
                    w_cnt_nxt   = '0;
                end
            end
`endif

            c_S_GAP: begin
                if (r_cnt == c_GAP_LAST) begin
                    w_state_nxt = c_S_IDLE;
                    w_busy_nxt  = 1'b0;
                end else begin
                    w_cnt_nxt = r_cnt + c_CNT_ONE;
                end
            end

            default: begin
                w_state_nxt = c_S_IDLE;
                w_busy_nxt  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_S_IDLE;
            r_cnt   <= '0;
            r_sh    <= '0;
            r_y     <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
`ifdef SEQ_1010_TX_PARITY_EN
            r_par   <= 1'b0;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_sh    <= w_sh_nxt;
            r_y     <= w_y_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
`ifdef SEQ_1010_TX_PARITY_EN
            r_par   <= w_par_nxt;
`endif
        end
    end

endmodule
`default_nettype wire
